// File: rtl/fifo_core.sv
// rtl/fifo_core.sv - circular-buffer FIFO storage engine with FWFT head output
//
// Purpose: stores WIDTH-bit words in a 2**POINTER_WIDTH-deep register array.
// The head word is presented first-word-fall-through, so a reader can capture
// it in the same cycle that it pops. Full, empty, count and the almost levels
// are decoded from the count register.
//
// Optional feature macro: FIFO_CORE_ERR_FLAGS_EN
//   defined   -> sticky overflow/underflow flags, cleared by err_clear
//   undefined -> overflow/underflow tied to 0, err_clear ignored
//
// Ports:
//   clk              in   clock; all state updates on the rising edge
//   reset            in   synchronous active-high reset
//   wr_en            in   push request, one word per asserted cycle
//   fifo_input_data  in   word to push
//   rd_en            in   pop request, one word per asserted cycle
//   err_clear        in   clears the sticky error flags
//   fifo_output_data out  head word, or 0 when empty
//   full             out  count == DEPTH
//   empty            out  count == 0
//   count            out  number of stored words, 0..DEPTH
//   almost_full      out  count >= ALMOST_FULL_LEVEL
//   almost_empty     out  count <= ALMOST_EMPTY_LEVEL
//   overflow         out  sticky: a push was rejected
//   underflow        out  sticky: a pop was rejected
module fifo_core #(
  parameter int WIDTH              = 8,
  parameter int POINTER_WIDTH      = 4,
  parameter int ALMOST_FULL_LEVEL  = 14,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         fifo_input_data,
  input  logic                     rd_en,
  input  logic                     err_clear,
  output logic [WIDTH-1:0]         fifo_output_data,
  output logic                     full,
  output logic                     empty,
  output logic [POINTER_WIDTH:0]   count,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int DEPTH = 2 ** POINTER_WIDTH;
  localparam logic [POINTER_WIDTH:0]   DEPTH_C  = (POINTER_WIDTH + 1)'(DEPTH);
  localparam logic [POINTER_WIDTH:0]   AF_LEVEL = (POINTER_WIDTH + 1)'(ALMOST_FULL_LEVEL);
  localparam logic [POINTER_WIDTH:0]   AE_LEVEL = (POINTER_WIDTH + 1)'(ALMOST_EMPTY_LEVEL);
  localparam logic [POINTER_WIDTH-1:0] PTR_ONE  = (POINTER_WIDTH)'(1);
  localparam logic [POINTER_WIDTH:0]   CNT_ONE  = (POINTER_WIDTH + 1)'(1);

  logic [WIDTH-1:0]         mem [DEPTH];
  logic [POINTER_WIDTH-1:0] wr_ptr;
  logic [POINTER_WIDTH-1:0] rd_ptr;
  logic                     pop_ok;
  logic                     push_ok;

  // Status is a pure decode of the count register.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_LEVEL);
  assign almost_empty = (count <= AE_LEVEL);

  // A push into a full FIFO is legal only when a pop frees a slot in the
  // same cycle; this keeps 1 word/cycle throughput at full occupancy.
  assign pop_ok  = rd_en && !empty;
  assign push_ok = wr_en && (!full || pop_ok);

  assign fifo_output_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push_ok && !pop_ok) begin
        count <= count + CNT_ONE;
      end else if (pop_ok && !push_ok) begin
        count <= count - CNT_ONE;
      end
    end
  end

  // Storage is not reset; the reset cycle must still not write a word.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      mem[wr_ptr] <= fifo_input_data;
    end
  end

`ifdef FIFO_CORE_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  // Clear first, then set, so a new error in the clear cycle is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (err_clear) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end
      if (wr_en && !push_ok) overflow_q  <= 1'b1;
      if (rd_en && !pop_ok)  underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_err_clear;
  assign unused_err_clear = err_clear;
  assign overflow         = 1'b0;
  assign underflow        = 1'b0;
`endif

endmodule
